pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline registers (pc, if_id, id_ex, ex_mem, mem_wb). It detects load-use hazards and inserts a configurable number of bubbles. It flushes wrong-path stages when a branch resolves taken in MEM, and freezes the whole pipe while the data memory handshake is outstanding. A timeout on that handshake raises a sticky fault.

Parameters:
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1 with MEM forwarding, 2 without); legal range 1..3
MEM_TIMEOUT, 255, max consecutive wait cycles before fault; counter width $clog2(MEM_TIMEOUT+1)
ADDR_W, 32, instruction address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
id_rs1_addr_i  in  5  rs1 of instruction in ID
id_rs2_addr_i  in  5  rs2 of instruction in ID
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
ex_mem_read_i  in  1  instruction in EX is a load
ex_write_addr_i  in  5  rd of instruction in EX
mem_branch_i  in  1  instruction in MEM is a branch
mem_branch_take_i  in  1  its condition resolved taken
mem_branch_pc_i  in  ADDR_W  branch target from ex_mem
mem_access_i  in  1  MEM instruction reads/writes data memory
dmem_ack_i  in  1  data memory completes access this cycle
stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o  out  1 each  hold register
flush_if_id_o, flush_id_ex_o, flush_ex_mem_o  out  1 each  load bubble (all-zero control) next edge
pc_redirect_o  out  1  load pc from pc_redirect_addr_o
pc_redirect_addr_o  out  ADDR_W  redirect target
mem_fault_o  out  1  sticky memory-timeout fault
stall_cycles_o  out  32  perf counter (see Optional Feature)
flush_count_o  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset: rst high at edge -> state RUN, bubble/timeout counters 0, mem_fault_o 0, perf counters 0. While rst high all outputs 0 and pc_redirect_addr_o 0. Reset mid-wait or mid-bubble abandons the sequence.
- Registered: state, counters, mem_fault_o. Stall/flush/redirect are combinational from state+inputs (zero latency).
- Hazard: ex_mem_read_i && ex_write_addr_i!=0 && ((id_rs1_used_i && rs1==rd) || (id_rs2_used_i && rs2==rd)). rd==x0 never hazards.
- mem_busy = mem_access_i && !dmem_ack_i.
- States: RUN, LOAD_BUBBLE, MEM_WAIT, FAULT.
- Priority every cycle: mem_busy > branch taken > load-use.
- RUN:
  - mem_busy: all five stalls high, no flush, tcnt<=1, next MEM_WAIT.
  - Else mem_branch_i && mem_branch_take_i: flush_if_id/id_ex/ex_mem high, pc_redirect_o high, addr = mem_branch_pc_i, no stalls, stay RUN.
  - Else hazard: stall_pc, stall_if_id, flush_id_ex high. If LOAD_USE_BUBBLES>1, bcnt<=LOAD_USE_BUBBLES-1 and next LOAD_BUBBLE; else stay RUN.
- LOAD_BUBBLE: stall_pc, stall_if_id, flush_id_ex high; bcnt decrements; at bcnt==1, next RUN.
  - mem_busy overrides: freeze all, bcnt held, stay in LOAD_BUBBLE, timeout counts.
  - Taken branch: flush/redirect as RUN, bcnt<=0, next RUN.
- MEM_WAIT: all stalls high while !dmem_ack_i; tcnt increments.
  - dmem_ack_i: stalls low that cycle (pipe advances), next RUN, tcnt<=0. Branch/hazard inputs are then evaluated as in RUN.
  - Ack on the same cycle tcnt reaches MEM_TIMEOUT: ack wins.
  - tcnt==MEM_TIMEOUT && !ack: mem_fault_o<=1, next FAULT.
- FAULT: all stalls high, no flush/redirect, until rst.
- pc_redirect_addr_o = mem_branch_pc_i when redirecting, else 0.

Optional Feature:
PIPE_PERF_CNT_EN. Defined: stall_cycles_o counts cycles with stall_pc_o high; flush_count_o counts cycles with pc_redirect_o high; both 32-bit wrap 0xFFFFFFFF->0 and clear on rst. Undefined: both ports tied 0, no counter flops.

Decomposition:
- pipe_ctrl_pkg: state encodings (RUN=2'b00, LOAD_BUBBLE=2'b01, MEM_WAIT=2'b10, FAULT=2'b11), Asserted/Deasserted, x0 address constant.
- Sub-module load_use_detect: combinational hazard compare, reused by the future forwarding unit.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 (used) -> 1 cycle stall_pc/stall_if_id/flush_id_ex, then clear; with LOAD_USE_BUBBLES=2 -> exactly 2 such cycles.
- Load writes x0, ID reads x0 -> no stall, no flush.
- mem_branch_i=1, take=1, target 0x0000_0100 -> same cycle 3 flushes, pc_redirect_o=1, addr 0x100; take=0 -> nothing asserted.
- mem_access_i=1, ack after 4 cycles -> 4 cycles all stalls high, released on ack cycle, state RUN.
- MEM_TIMEOUT=8, ack never -> mem_fault_o rises after 8 wait cycles, stalls stay high; rst -> all outputs 0, RUN.
- Branch taken and load-use same cycle -> flush/redirect only, no stall; mem_busy with branch taken -> freeze only, redirect after ack.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and its helpers.
package pipe_ctrl_pkg;

  typedef logic [1:0] ctrl_state_t;

  localparam ctrl_state_t ST_RUN         = 2'b00;
  localparam ctrl_state_t ST_LOAD_BUBBLE = 2'b01;
  localparam ctrl_state_t ST_MEM_WAIT    = 2'b10;
  localparam ctrl_state_t ST_FAULT       = 2'b11;

  localparam logic ASSERTED   = 1'b1;
  localparam logic DEASSERTED = 1'b0;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic [4:0]        id_rs1_addr_i;
  logic [4:0]        id_rs2_addr_i;
  logic              id_rs1_used_i;
  logic              id_rs2_used_i;
  logic              ex_mem_read_i;
  logic [4:0]        ex_write_addr_i;
  logic              mem_branch_i;
  logic              mem_branch_take_i;
  logic [ADDR_W-1:0] mem_branch_pc_i;
  logic              mem_access_i;
  logic              dmem_ack_i;

  logic              stall_pc_o;
  logic              stall_if_id_o;
  logic              stall_id_ex_o;
  logic              stall_ex_mem_o;
  logic              stall_mem_wb_o;
  logic              flush_if_id_o;
  logic              flush_id_ex_o;
  logic              flush_ex_mem_o;
  logic              pc_redirect_o;
  logic [ADDR_W-1:0] pc_redirect_addr_o;
  logic              mem_fault_o;
  logic [31:0]       stall_cycles_o;
  logic [31:0]       flush_count_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           ex_mem_read_i, ex_write_addr_i, mem_branch_i, mem_branch_take_i,
           mem_branch_pc_i, mem_access_i, dmem_ack_i,
    input  stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o,
           flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, pc_redirect_o,
           pc_redirect_addr_o, mem_fault_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           ex_mem_read_i, ex_write_addr_i, mem_branch_i, mem_branch_take_i,
           mem_branch_pc_i, mem_access_i, dmem_ack_i,
    output stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o,
           flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, pc_redirect_o,
           pc_redirect_addr_o, mem_fault_o, stall_cycles_o, flush_count_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the load in EX and the sources of ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_write_addr_i,
  output logic       hazard_o
);

  // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
  assign hazard_o = ex_mem_read_i && (ex_write_addr_i != REG_X0) &&
                    ((rs1_used_i && (rs1_addr_i == ex_write_addr_i)) ||
                     (rs2_used_i && (rs2_addr_i == ex_write_addr_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Define PIPE_PERF_CNT_EN to build the stall/redirect performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 255,
  parameter int unsigned ADDR_W           = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned       TCNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(MEM_TIMEOUT);
  localparam logic [1:0]        BCNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

  ctrl_state_t       state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic              fault_q, fault_d;

  logic hazard, mem_busy, branch_taken, run_eval;
  logic freeze_all, stall_front, bubble_id_ex, redirect;
  logic stall_pc, pc_redirect;

  load_use_detect u_load_use_detect (
    .rs1_addr_i      (bus.id_rs1_addr_i),
    .rs2_addr_i      (bus.id_rs2_addr_i),
    .rs1_used_i      (bus.id_rs1_used_i),
    .rs2_used_i      (bus.id_rs2_used_i),
    .ex_mem_read_i   (bus.ex_mem_read_i),
    .ex_write_addr_i (bus.ex_write_addr_i),
    .hazard_o        (hazard)
  );

  assign mem_busy     = bus.mem_access_i && !bus.dmem_ack_i;
  assign branch_taken = bus.mem_branch_i && bus.mem_branch_take_i;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    fault_d      = fault_q;
    run_eval     = DEASSERTED;
    freeze_all   = DEASSERTED;
    stall_front  = DEASSERTED;
    bubble_id_ex = DEASSERTED;
    redirect     = DEASSERTED;

    case (state_q)
      ST_RUN: run_eval = ASSERTED;

      ST_LOAD_BUBBLE: begin
        if (mem_busy) begin
          freeze_all = ASSERTED;
          if (tcnt_q == TCNT_MAX) begin
            fault_d = ASSERTED;
            state_d = ST_FAULT;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end else if (branch_taken) begin
          redirect = ASSERTED;
          bcnt_d   = '0;
          tcnt_d   = '0;
          state_d  = ST_RUN;
        end else begin
          stall_front  = ASSERTED;
          bubble_id_ex = ASSERTED;
          tcnt_d       = '0;
          bcnt_d       = bcnt_q - 2'd1;
          if (bcnt_q == 2'd1) state_d = ST_RUN;
        end
      end

      // Only the acknowledge releases a pending access; the pipe then acts as in RUN.
      ST_MEM_WAIT: begin
        if (!bus.dmem_ack_i) begin
          freeze_all = ASSERTED;
          if (tcnt_q == TCNT_MAX) begin
            fault_d = ASSERTED;
            state_d = ST_FAULT;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end else begin
          tcnt_d   = '0;
          run_eval = ASSERTED;
        end
      end

      default: freeze_all = ASSERTED;
    endcase

    if (run_eval) begin
      if (mem_busy) begin
        freeze_all = ASSERTED;
        tcnt_d     = TCNT_W'(1);
        state_d    = ST_MEM_WAIT;
      end else if (branch_taken) begin
        redirect = ASSERTED;
        state_d  = ST_RUN;
      end else if (hazard) begin
        stall_front  = ASSERTED;
        bubble_id_ex = ASSERTED;
        if (LOAD_USE_BUBBLES > 1) begin
          bcnt_d  = BCNT_INIT;
          state_d = ST_LOAD_BUBBLE;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_RUN;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      fault_q <= DEASSERTED;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      fault_q <= fault_d;
    end
  end

  // Controls are forced low while reset is held, regardless of the registered state.
  assign stall_pc    = !rst && (freeze_all || stall_front);
  assign pc_redirect = !rst && redirect;

  assign bus.stall_pc_o         = stall_pc;
  assign bus.stall_if_id_o      = stall_pc;
  assign bus.stall_id_ex_o      = !rst && freeze_all;
  assign bus.stall_ex_mem_o     = !rst && freeze_all;
  assign bus.stall_mem_wb_o     = !rst && freeze_all;
  assign bus.flush_if_id_o      = pc_redirect;
  assign bus.flush_id_ex_o      = !rst && (redirect || bubble_id_ex);
  assign bus.flush_ex_mem_o     = pc_redirect;
  assign bus.pc_redirect_o      = pc_redirect;
  assign bus.pc_redirect_addr_o = pc_redirect ? bus.mem_branch_pc_i : '0;
  assign bus.mem_fault_o        = fault_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  assign stall_cycles_d = stall_cycles_q + 32'(stall_pc);
  assign flush_count_d  = flush_count_q + 32'(pc_redirect);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles_o = stall_cycles_q;
  assign bus.flush_count_o  = flush_count_q;
`else
  assign bus.stall_cycles_o = '0;
  assign bus.flush_count_o  = '0;
`endif

endmodule
